// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundles the hazard-relevant pipeline fields and the register control outputs.
// Combinational path only; the interface itself holds no state.
// No backpressure: the hazard unit throttles the pipeline through its enables.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             mem_branch;
    logic             mem_zero;
    logic             mem_access;
    logic             mem_ready;
    logic             pc_we;
    logic             pc_src_branch;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_we;
    logic             id_ex_bubble;
    logic             ex_mem_we;
    logic             ex_mem_flush;
    logic             mem_wb_bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;

    // Pipeline side: presents instruction fields, consumes register controls.
    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               mem_branch, mem_zero, mem_access, mem_ready,
        input  pc_we, pc_src_branch, if_id_we, if_id_flush, id_ex_we,
               id_ex_bubble, ex_mem_we, ex_mem_flush, mem_wb_bubble,
               stall_cnt, flush_cnt, mem_timeout
    );

    // Hazard controller side.
    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               mem_branch, mem_zero, mem_access, mem_ready,
        output pc_we, pc_src_branch, if_id_we, if_id_flush, id_ex_we,
               id_ex_bubble, ex_mem_we, ex_mem_flush, mem_wb_bubble,
               stall_cnt, flush_cnt, mem_timeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer: stall/flush/bubble controls for the five-stage pipeline registers.
// Controls are combinational from current inputs and valid bits; counters update on posedge.
// Memory wait freezes every stage; load-use stalls PC and IF/ID for exactly one cycle.
module pipeline_hazard_ctrl #(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    pipeline_hazard_ctrl_if.slave   hz
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              timeout_set;
    logic              v_id, v_ex, v_mem;
    logic              v_id_nxt, v_ex_nxt, v_mem_nxt;
    logic              memw, br, lu;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
    logic              mem_timeout;

    // Hazard detection in priority order: memory wait, taken branch, load-use.
    always_comb begin
        memw = v_mem & hz.mem_access & ~hz.mem_ready;
        br   = v_mem & hz.mem_branch & hz.mem_zero & ~memw;
        lu   = v_ex & v_id & hz.ex_mem_read & (hz.ex_rt != 5'd0) &
               ((hz.ex_rt == hz.id_rs) | (hz.id_uses_rt & (hz.ex_rt == hz.id_rt))) &
               ~memw & ~br;
    end

    // Register controls and next valid bits; bubbles never raise hazards.
    always_comb begin
        hz.pc_we         = 1'b1;
        hz.pc_src_branch = 1'b0;
        hz.if_id_we      = 1'b1;
        hz.if_id_flush   = 1'b0;
        hz.id_ex_we      = 1'b1;
        hz.id_ex_bubble  = 1'b0;
        hz.ex_mem_we     = 1'b1;
        hz.ex_mem_flush  = 1'b0;
        hz.mem_wb_bubble = 1'b0;
        v_id_nxt         = 1'b1;
        v_ex_nxt         = v_id;
        v_mem_nxt        = v_ex;
        if (memw) begin
            hz.pc_we         = 1'b0;
            hz.if_id_we      = 1'b0;
            hz.id_ex_we      = 1'b0;
            hz.ex_mem_we     = 1'b0;
            hz.mem_wb_bubble = 1'b1;
            v_id_nxt         = v_id;
            v_ex_nxt         = v_ex;
            v_mem_nxt        = v_mem;
        end else if (br) begin
            hz.pc_src_branch = 1'b1;
            hz.if_id_flush   = 1'b1;
            hz.id_ex_bubble  = 1'b1;
            hz.ex_mem_flush  = 1'b1;
            v_id_nxt         = 1'b0;
            v_ex_nxt         = 1'b0;
            v_mem_nxt        = 1'b0;
        end else if (lu) begin
            hz.pc_we         = 1'b0;
            hz.if_id_we      = 1'b0;
            hz.id_ex_bubble  = 1'b1;
            v_id_nxt         = v_id;
            v_ex_nxt         = 1'b0;
            v_mem_nxt        = v_ex;
        end
    end

    // Wait FSM next state: count MEM_WAIT cycles, saturating; leave on the ready cycle.
    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        timeout_set = 1'b0;
        case (state)
            RUN: begin
                if (memw) state_nxt = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (memw) begin
                    if (wait_cnt != WAIT_LIM) wait_nxt = wait_cnt + 1'b1;
                    timeout_set = (wait_nxt == WAIT_LIM);
                end else begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // State, valid bits, saturating counters and sticky timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            v_id        <= 1'b0;
            v_ex        <= 1'b0;
            v_mem       <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            v_id     <= v_id_nxt;
            v_ex     <= v_ex_nxt;
            v_mem    <= v_mem_nxt;
            if ((memw | lu) && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
            if (br && flush_cnt != CNT_MAX)          flush_cnt <= flush_cnt + 1'b1;
            if (timeout_set)                         mem_timeout <= 1'b1;
        end
    end

    // Expose status registers on the interface.
    always_comb begin
        hz.stall_cnt   = stall_cnt;
        hz.flush_cnt   = flush_cnt;
        hz.mem_timeout = mem_timeout;
    end
endmodule
